// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, fetches one word at a time over a
// ready handshake, buffers a fetch that lands during a stall, and squashes wrong-path data.
module if_stage #(
  parameter int                WORD      = 64,
  parameter int                INST_SIZE = 32,
  parameter logic [WORD-1:0]   RESET_PC  = {WORD{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [WORD-1:0]      br_target,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic [INST_SIZE-1:0] imem_rdata,
  output logic                 if_valid,
  output logic [WORD-1:0]      if_pc,
  output logic [INST_SIZE-1:0] if_inst
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam logic [WORD-1:0]      ZERO_W   = {WORD{1'b0}};
  localparam logic [INST_SIZE-1:0] ZERO_I   = {INST_SIZE{1'b0}};
  localparam logic [WORD-1:0]      PC_STEP  = {{(WORD-3){1'b0}}, 3'b100};
  localparam logic [WORD-1:0]      PC_RESET = {RESET_PC[WORD-1:2], 2'b00};

  state_e                 state_q, state_d;
  logic [WORD-1:0]        pc_q, pc_d;
  logic [WORD-1:0]        drop_addr_q, drop_addr_d;
  logic [WORD-1:0]        hold_pc_q, hold_pc_d;
  logic [INST_SIZE-1:0]   hold_inst_q, hold_inst_d;
  logic                   valid_q, valid_d;
  logic [WORD-1:0]        ifpc_q, ifpc_d;
  logic [INST_SIZE-1:0]   ifinst_q, ifinst_d;
  logic                   req_q, req_d;
  logic [WORD-1:0]        addr_q, addr_d;

  logic                   stall_eff_s;
  logic [WORD-1:0]        br_pc_s;
  logic [WORD-1:0]        pc_inc_s;

  assign stall_eff_s = stall & valid_q;
  assign br_pc_s     = {br_target[WORD-1:2], 2'b00};
  assign pc_inc_s    = pc_q + PC_STEP;

  // Next-state, PC, hold buffer and IF/ID update; redirect wins over stall and completion
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    valid_d     = valid_q;
    ifpc_d      = ifpc_q;
    ifinst_d    = ifinst_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (br_taken) begin
          pc_d        = br_pc_s;
          valid_d     = 1'b0;
          hold_pc_d   = ZERO_W;
          hold_inst_d = ZERO_I;
          if (imem_ready) begin
            state_d = ST_REQ;
          end else begin
            state_d     = ST_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc_s;
          if (stall_eff_s) begin
            hold_pc_d   = pc_q;
            hold_inst_d = imem_rdata;
            state_d     = ST_HOLD;
          end else begin
            valid_d  = 1'b1;
            ifpc_d   = pc_q;
            ifinst_d = imem_rdata;
            state_d  = ST_REQ;
          end
        end else if (!stall_eff_s) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          pc_d        = br_pc_s;
          valid_d     = 1'b0;
          hold_pc_d   = ZERO_W;
          hold_inst_d = ZERO_I;
          state_d     = ST_REQ;
        end else if (!stall_eff_s) begin
          valid_d  = 1'b1;
          ifpc_d   = hold_pc_q;
          ifinst_d = hold_inst_q;
          state_d  = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        // The in-flight word belongs to the abandoned path; only the PC may move here
        if (br_taken) begin
          pc_d    = br_pc_s;
          valid_d = 1'b0;
        end else begin
          pc_d = pc_q;
        end
        if (imem_ready) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory-side outputs are precomputed from the next state so they leave a flop
  always_comb begin
    req_d  = (state_d == ST_REQ) || (state_d == ST_DROP);
    addr_d = pc_d;
    if (state_d == ST_DROP) begin
      addr_d = drop_addr_d;
    end else begin
      addr_d = pc_d;
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= PC_RESET;
      drop_addr_q <= ZERO_W;
      hold_pc_q   <= ZERO_W;
      hold_inst_q <= ZERO_I;
      valid_q     <= 1'b0;
      ifpc_q      <= ZERO_W;
      ifinst_q    <= ZERO_I;
      req_q       <= 1'b0;
      addr_q      <= ZERO_W;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      valid_q     <= valid_d;
      ifpc_q      <= ifpc_d;
      ifinst_q    <= ifinst_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_pc     = ifpc_q;
  assign if_inst   = ifinst_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// checked against a program-order model of the delivered instruction stream.
module tb_if_stage;
  localparam logic [31:0] XOR_K = 32'hF84402C9;
  localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, br_taken, imem_ready;
  logic [63:0] br_target;
  logic        imem_req, if_valid;
  logic [63:0] imem_addr, if_pc;
  logic [31:0] imem_rdata, if_inst;

  logic        b_stall, b_ready, b_br;
  logic [63:0] b_target;
  logic        b_req, b_valid;
  logic [63:0] b_addr, b_pc;
  logic [31:0] b_rdata, b_inst;

  assign imem_rdata = imem_addr[31:0] ^ XOR_K;
  assign b_rdata    = b_addr[31:0] ^ XOR_K;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  if_stage #(.RESET_PC(TOP_PC)) dut_top (
    .clk(clk), .rst_n(rst_n), .stall(b_stall), .br_taken(b_br), .br_target(b_target),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(b_ready), .imem_rdata(b_rdata),
    .if_valid(b_valid), .if_pc(b_pc), .if_inst(b_inst)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [63:0] a);
    logic [31:0] w;
    w = a[31:0] ^ XOR_K;
    return {32'h0, w};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 64'h0; imem_ready = 1'b1;
    b_stall = 1'b0; b_ready = 1'b1; b_br = 1'b0; b_target = 64'h0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        pv, preq;
    logic [63:0] ppc, paddr, exp_pc, tgt;
    logic [31:0] pinst;
    int          idle;

    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 64'h0; imem_ready = 1'b1;
    b_stall = 1'b0; b_ready = 1'b1; b_br = 1'b0; b_target = 64'h0;
    step();
    step();
    check("rst_req",   imem_req,  64'h0);
    check("rst_addr",  imem_addr, 64'h0);
    check("rst_valid", if_valid,  64'h0);
    check("rst_pc",    if_pc,     64'h0);
    check("rst_inst",  if_inst,   64'h0);
    check("rst_b_pc",  b_pc,      64'h0);

    // zero-wait sequential fetch, plus the wrap-around instance
    do_reset();
    check("t1_first_req",   imem_req,  64'h1);
    check("t1_first_addr",  imem_addr, 64'h0);
    check("t1_no_valid",    if_valid,  64'h0);
    check("t1_b_addr",      b_addr,    TOP_PC);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_valid", if_valid, 64'h1);
      check("t1_pc",    if_pc,    64'(i * 4));
      check("t1_inst",  if_inst,  word_of(64'(i * 4)));
      if (i < 3) begin
        check("t1_b_valid", b_valid, 64'h1);
        check("t1_b_pc",    b_pc,    TOP_PC + 64'(i * 4));
        check("t1_b_inst",  b_inst,  word_of(TOP_PC + 64'(i * 4)));
      end
    end

    // async reset while a fetch waits on the wrap-around instance
    b_stall = 1'b1; b_ready = 1'b0;
    step();
    check("t6_b_held_valid", b_valid, 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", b_valid, 64'h0);
    check("t6_async_req",   b_req,   64'h0);
    check("t6_async_pc",    b_pc,    64'h0);
    do_reset();
    check("t6_restart_addr", b_addr, TOP_PC);
    step();
    check("t6_restart_pc", b_pc, TOP_PC);

    // two wait states at address 0x8
    do_reset();
    step();
    step();
    check("t2_addr8", imem_addr, 64'h8);
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_bubble", if_valid,  64'h0);
      check("t2_req",    imem_req,  64'h1);
      check("t2_addr",   imem_addr, 64'h8);
    end
    imem_ready = 1'b1;
    step();
    check("t2_valid",    if_valid,  64'h1);
    check("t2_pc",       if_pc,     64'h8);
    check("t2_next_req", imem_addr, 64'hC);

    // three-cycle stall while IF/ID holds 0x4
    do_reset();
    step();
    step();
    check("t3_pc4", if_pc, 64'h4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_pc",    if_pc,    64'h4);
      check("t3_hold_valid", if_valid, 64'h1);
      check("t3_hold_req",   imem_req, 64'h0);
    end
    stall = 1'b0;
    step();
    check("t3_rel_pc",   if_pc,     64'h8);
    check("t3_rel_inst", if_inst,   word_of(64'h8));
    check("t3_rel_req",  imem_req,  64'h1);
    check("t3_rel_addr", imem_addr, 64'hC);
    step();
    check("t3_next_pc",    if_pc,    64'hC);
    check("t3_next_valid", if_valid, 64'h1);

    // zero-wait redirect to 0x43 during fetch of 0x10
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("t4_addr10", imem_addr, 64'h10);
    br_taken = 1'b1; br_target = 64'h43;
    step();
    br_taken = 1'b0;
    check("t4_bubble", if_valid,  64'h0);
    check("t4_target", imem_addr, 64'h40);
    step();
    check("t4_valid40", if_valid, 64'h1);
    check("t4_pc40",    if_pc,    64'h40);
    check("t4_inst40",  if_inst,  word_of(64'h40));
    step();
    check("t4_pc44", if_pc, 64'h44);

    // redirect to 0x100 while 0x8 is outstanding
    do_reset();
    step();
    step();
    imem_ready = 1'b0;
    step();
    br_taken = 1'b1; br_target = 64'h100;
    step();
    br_taken = 1'b0;
    check("t5_drop_req",  imem_req,  64'h1);
    check("t5_drop_addr", imem_addr, 64'h8);
    check("t5_drop_val",  if_valid,  64'h0);
    step();
    check("t5_drop_addr2", imem_addr, 64'h8);
    imem_ready = 1'b1;
    step();
    check("t5_discard", if_valid,  64'h0);
    check("t5_new_req", imem_addr, 64'h100);
    step();
    check("t5_pc100",  if_pc,    64'h100);
    check("t5_val100", if_valid, 64'h1);

    // randomized traffic against the program-order model
    do_reset();
    exp_pc = 64'h0;
    idle = 0;
    for (int n = 0; n < 3000; n++) begin
      imem_ready = ($urandom_range(9) < 7);
      stall      = ($urandom_range(9) < 2);
      br_taken   = ($urandom_range(19) == 0);
      tgt        = ($urandom_range(3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(4095));
      br_target  = tgt;
      pv = if_valid; ppc = if_pc; pinst = if_inst; preq = imem_req; paddr = imem_addr;
      step();
      if (preq && !imem_ready) begin
        check("rnd_req_kept",  imem_req,  64'h1);
        check("rnd_addr_kept", imem_addr, paddr);
      end
      if (br_taken) begin
        check("rnd_br_squash", if_valid, 64'h0);
        exp_pc = {tgt[63:2], 2'b00};
        idle = 0;
      end else if (stall && pv) begin
        check("rnd_stall_valid", if_valid, 64'h1);
        check("rnd_stall_pc",    if_pc,    ppc);
        check("rnd_stall_inst",  if_inst,  {32'h0, pinst});
        idle = 0;
      end else if (if_valid) begin
        check("rnd_pc",   if_pc,   exp_pc);
        check("rnd_inst", if_inst, word_of(exp_pc));
        exp_pc = exp_pc + 64'd4;
        idle = 0;
      end else begin
        idle++;
        if (idle > 40) begin
          check("rnd_liveness", 64'(idle), 64'h0);
          idle = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
